// File: rtl/conv_layer_sequencer.sv
// Instruction-driven sequencer for the convolution datapath: weight BRAM fill,
// weight preload/load into the MAC array, and ifmap streaming with ping-pong BRAM banks.
module conv_layer_sequencer #(
    parameter int MAC_NUM        = 256,
    parameter int BEAT_CNT_WIDTH = 17,
    parameter int WAIT_TIMEOUT   = 1024
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      inst_valid,
    output logic                      inst_ready,
    input  logic [31:0]               inst_data,
    input  logic [1:0]                cfg_operation,
    input  logic [11:0]               cfg_in_ch,
    input  logic [11:0]               cfg_out_ch,
    input  logic [4:0]                cfg_kernel,
    input  logic [MAC_NUM-1:0]        cfg_mac_enable,
    output logic [1:0]                operation,
    output logic [11:0]               input_channel_size,
    output logic [11:0]               output_channel_size,
    output logic [4:0]                kernel_size,
    output logic [MAC_NUM-1:0]        mac_enable,
    output logic                      bram_write_en,
    output logic                      bram_transfer_start,
    output logic                      bram_control_add1,
    output logic                      bram_control_add2,
    output logic                      port_sel,
    output logic                      load_weight_preload,
    output logic                      load_weight,
    output logic                      load_ifmaps,
    input  logic                      ifmaps_fifo_empty,
    input  logic                      weight_from_bram_valid,
    input  logic                      write_weight_finish,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    localparam int WAIT_W = $clog2(WAIT_TIMEOUT + 1);

    localparam logic [31:0] OP_WRITE_WEIGHT = 32'd86;
    localparam logic [31:0] OP_COMPUTE      = 32'd87;
    localparam logic [31:0] OP_LOADIFMAPS   = 32'd88;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_W,
        S_XFER,
        S_PRE,
        S_LDW,
        S_STREAM,
        S_FIN
    } state_t;

    state_t                    state_q, state_d;
    logic [1:0]                operation_q;
    logic [11:0]               in_ch_q;
    logic [11:0]               out_ch_q;
    logic [4:0]                kernel_q;
    logic [MAC_NUM-1:0]        mac_en_q;
    logic [BEAT_CNT_WIDTH-1:0] beat_q, beat_d;
    logic [WAIT_W-1:0]         wait_q, wait_d;
    logic                      is_compute_q, is_compute_d;
    logic                      port_sel_q, port_sel_d;
    logic                      err_q, err_d;

    logic                      accept;
    logic                      kernel_ok;
    logic                      wait_expired;
    logic [BEAT_CNT_WIDTH-1:0] target;

    assign accept       = inst_valid && (state_q == S_IDLE);
    assign kernel_ok    = (cfg_kernel != 5'd0) && (cfg_kernel <= 5'd5);
    assign wait_expired = (wait_q == WAIT_W'(WAIT_TIMEOUT - 1));
    // Widen before multiplying so 12-bit channels x 5-bit kernel never truncates.
    assign target       = BEAT_CNT_WIDTH'(in_ch_q) * BEAT_CNT_WIDTH'(kernel_q);

    always_comb begin
        state_d             = state_q;
        beat_d              = beat_q;
        wait_d              = '0;
        is_compute_d        = is_compute_q;
        port_sel_d          = port_sel_q;
        err_d               = 1'b0;
        bram_write_en       = 1'b0;
        bram_transfer_start = 1'b0;
        bram_control_add1   = 1'b0;
        bram_control_add2   = 1'b0;
        load_weight_preload = 1'b0;
        load_weight         = 1'b0;
        load_ifmaps         = 1'b0;
        done                = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    is_compute_d = 1'b0;
                    beat_d       = '0;
                    if (!kernel_ok) begin
                        err_d = 1'b1;
                    end else if (inst_data == OP_WRITE_WEIGHT) begin
                        state_d = S_WR_W;
                    end else if (inst_data == OP_COMPUTE) begin
                        state_d      = S_XFER;
                        is_compute_d = 1'b1;
                    end else if (inst_data == OP_LOADIFMAPS) begin
                        state_d = S_STREAM;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_WR_W: begin
                bram_write_en = 1'b1;
                if (write_weight_finish) begin
                    state_d = S_FIN;
                end else if (wait_expired) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_XFER: begin
                bram_transfer_start = 1'b1;
                state_d             = S_PRE;
            end
            S_PRE: begin
                if (weight_from_bram_valid) begin
                    load_weight_preload = 1'b1;
                    bram_control_add1   = 1'b1;
                    state_d             = S_LDW;
                end else if (wait_expired) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_LDW: begin
                load_weight = 1'b1;
                state_d     = S_STREAM;
            end
            S_STREAM: begin
                if (target == '0) begin
                    state_d = S_FIN;
                end else if (!ifmaps_fifo_empty) begin
                    load_ifmaps = 1'b1;
                    if (beat_q == target - BEAT_CNT_WIDTH'(1)) begin
                        beat_d  = '0;
                        state_d = S_FIN;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
                if (is_compute_q) begin
                    bram_control_add2 = 1'b1;
                    port_sel_d        = !port_sel_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            beat_q       <= '0;
            wait_q       <= '0;
            is_compute_q <= 1'b0;
            port_sel_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            wait_q       <= wait_d;
            is_compute_q <= is_compute_d;
            port_sel_q   <= port_sel_d;
            err_q        <= err_d;
        end
    end

    // Configuration is captured on every accept, including rejected instructions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            operation_q <= '0;
            in_ch_q     <= '0;
            out_ch_q    <= '0;
            kernel_q    <= '0;
            mac_en_q    <= '0;
        end else if (accept) begin
            operation_q <= cfg_operation;
            in_ch_q     <= cfg_in_ch;
            out_ch_q    <= cfg_out_ch;
            kernel_q    <= cfg_kernel;
            mac_en_q    <= cfg_mac_enable;
        end
    end

    assign inst_ready          = (state_q == S_IDLE);
    assign busy                = (state_q != S_IDLE);
    assign err                 = err_q;
    assign port_sel            = port_sel_q;
    assign operation           = operation_q;
    assign input_channel_size  = in_ch_q;
    assign output_channel_size = out_ch_q;
    assign kernel_size         = kernel_q;
    assign mac_enable          = mac_en_q;

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Scoreboard bench for conv_layer_sequencer: expected per-instruction activity is queued
// at issue and compared when the sequencer signals done or err.
module tb_conv_layer_sequencer;

    localparam int MAC_NUM = 256;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               inst_valid = 1'b0;
    logic               inst_ready;
    logic [31:0]        inst_data = '0;
    logic [1:0]         cfg_operation = '0;
    logic [11:0]        cfg_in_ch = '0;
    logic [11:0]        cfg_out_ch = '0;
    logic [4:0]         cfg_kernel = '0;
    logic [MAC_NUM-1:0] cfg_mac_enable = '0;
    logic [1:0]         operation;
    logic [11:0]        input_channel_size, output_channel_size;
    logic [4:0]         kernel_size;
    logic [MAC_NUM-1:0] mac_enable;
    logic bram_write_en, bram_transfer_start, bram_control_add1, bram_control_add2, port_sel;
    logic load_weight_preload, load_weight, load_ifmaps;
    logic ifmaps_fifo_empty;
    logic empty_fixed = 1'b0, empty_tog = 1'b0, tog_en = 1'b0;
    logic weight_from_bram_valid = 1'b0;
    logic write_weight_finish = 1'b0;
    logic busy, done, err;

    assign ifmaps_fifo_empty = tog_en ? empty_tog : empty_fixed;

    always #5 clk = ~clk;
    always @(posedge clk) begin
        #2;
        empty_tog = ~empty_tog;
    end

    conv_layer_sequencer #(.MAC_NUM(MAC_NUM), .BEAT_CNT_WIDTH(17), .WAIT_TIMEOUT(1024)) dut (
        .clk(clk), .rst_n(rst_n),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
        .cfg_operation(cfg_operation), .cfg_in_ch(cfg_in_ch), .cfg_out_ch(cfg_out_ch),
        .cfg_kernel(cfg_kernel), .cfg_mac_enable(cfg_mac_enable),
        .operation(operation), .input_channel_size(input_channel_size),
        .output_channel_size(output_channel_size), .kernel_size(kernel_size),
        .mac_enable(mac_enable),
        .bram_write_en(bram_write_en), .bram_transfer_start(bram_transfer_start),
        .bram_control_add1(bram_control_add1), .bram_control_add2(bram_control_add2),
        .port_sel(port_sel),
        .load_weight_preload(load_weight_preload), .load_weight(load_weight),
        .load_ifmaps(load_ifmaps),
        .ifmaps_fifo_empty(ifmaps_fifo_empty), .weight_from_bram_valid(weight_from_bram_valid),
        .write_weight_finish(write_weight_finish),
        .busy(busy), .done(done), .err(err)
    );

    typedef struct {
        string name;
        logic  is_err;
        int    beats, xfers, preloads, ldws, wr_cycles, add1s, add2s;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    int   n_vec = 0;
    int   n_miss = 0;

    int a_beats, a_xfers, a_pre, a_ldw, a_wr, a_add1, a_add2, a_empty_viol, a_excl;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input string n, input logic er, input int b, input int x,
                                input int p, input int l, input int w, input int a1, input int a2);
        exp_t r;
        r.name = n; r.is_err = er; r.beats = b; r.xfers = x; r.preloads = p;
        r.ldws = l; r.wr_cycles = w; r.add1s = a1; r.add2s = a2;
        return r;
    endfunction

    task automatic clear_acc();
        a_beats = 0; a_xfers = 0; a_pre = 0; a_ldw = 0; a_wr = 0;
        a_add1 = 0; a_add2 = 0; a_empty_viol = 0; a_excl = 0;
    endtask

    // Monitor: accumulate activity per instruction, compare against the queue on completion.
    always @(negedge clk) begin
        if (!rst_n) begin
            clear_acc();
        end else begin
            if (load_ifmaps) a_beats++;
            if (load_ifmaps && ifmaps_fifo_empty) a_empty_viol++;
            if (bram_transfer_start) a_xfers++;
            if (load_weight_preload) a_pre++;
            if (load_weight) a_ldw++;
            if (bram_write_en) a_wr++;
            if (bram_control_add1) a_add1++;
            if (bram_control_add2) a_add2++;
            if ((int'(bram_write_en) + int'(load_weight_preload) + int'(load_weight)
                 + int'(load_ifmaps)) > 1) a_excl++;
            if (done || err) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_completion", {30'b0, done, err}, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check({e.name, "_err"}, err, e.is_err);
                    check({e.name, "_done"}, done, !e.is_err);
                    check({e.name, "_beats"}, a_beats, e.beats);
                    check({e.name, "_xfer"}, a_xfers, e.xfers);
                    check({e.name, "_preload"}, a_pre, e.preloads);
                    check({e.name, "_ldw"}, a_ldw, e.ldws);
                    check({e.name, "_wr"}, a_wr, e.wr_cycles);
                    check({e.name, "_add1"}, a_add1, e.add1s);
                    check({e.name, "_add2"}, a_add2, e.add2s);
                    check({e.name, "_empty_viol"}, a_empty_viol, 0);
                    check({e.name, "_excl"}, a_excl, 0);
                end
                clear_acc();
            end
        end
    end

    logic [MAC_NUM-1:0] mac_pat;

    // Called at a negedge; returns #1 after the accepting posedge.
    task automatic issue(input logic [31:0] opc, input logic [1:0] op, input logic [11:0] ic,
                         input logic [11:0] oc, input logic [4:0] k, input exp_t ex);
        int t = 0;
        while (!inst_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (!inst_ready) check({ex.name, "_ready_timeout"}, 32'd0, 32'd1);
        for (int i = 0; i < MAC_NUM / 32; i++) mac_pat[i*32 +: 32] = $urandom;
        sb_q.push_back(ex);
        inst_data = opc; cfg_operation = op; cfg_in_ch = ic; cfg_out_ch = oc;
        cfg_kernel = k; cfg_mac_enable = mac_pat; inst_valid = 1'b1;
        @(posedge clk);
        #1;
        inst_valid = 1'b0;
        check({ex.name, "_cfg_op"}, operation, op);
        check({ex.name, "_cfg_in"}, input_channel_size, ic);
        check({ex.name, "_cfg_out"}, output_channel_size, oc);
        check({ex.name, "_cfg_k"}, kernel_size, k);
        check({ex.name, "_cfg_mac_lo"}, mac_enable[31:0], mac_pat[31:0]);
        check({ex.name, "_cfg_mac_hi"}, mac_enable[MAC_NUM-1 -: 32], mac_pat[MAC_NUM-1 -: 32]);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int t = 0;
        @(negedge clk);
        while (!(sb_q.size() == 0 && inst_ready) && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (t >= budget) begin
            check({tag, "_completion_timeout"}, 32'd0, 32'd1);
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int cnt;
        int lat;
        clear_acc();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ctrl_in_reset", {bram_write_en, bram_transfer_start, bram_control_add1,
              bram_control_add2, load_weight_preload, load_weight, load_ifmaps, done, err, busy}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", inst_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_port_sel", port_sel, 0);
        check("rst_cfg", {operation, input_channel_size, output_channel_size, kernel_size}, 0);
        check("rst_mac", mac_enable[31:0], 0);

        // WRITE_WEIGHT: finish arrives after 20 write-enable cycles
        issue(32'd86, 2'd1, 12'd8, 12'd16, 5'd3, mk("ww", 0, 0, 0, 0, 0, 20, 0, 0));
        cnt = 0;
        for (int i = 0; i < 100 && cnt < 20; i++) begin
            @(negedge clk);
            if (bram_write_en) cnt++;
        end
        write_weight_finish = 1'b1;
        @(negedge clk);
        write_weight_finish = 1'b0;
        check("ww_done_next", done, 1);
        check("ww_wen_off", bram_write_en, 0);
        wait_idle("ww", 50);
        check("ww_ready", inst_ready, 1);

        // COMPUTE 4x3, FIFO never empty
        weight_from_bram_valid = 1'b1;
        empty_fixed = 1'b0;
        issue(32'd87, 2'd2, 12'd4, 12'd8, 5'd3, mk("cmp", 0, 12, 1, 1, 1, 0, 1, 1));
        lat = 0;
        while (!load_ifmaps && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("cmp_latency", lat, 4);
        wait_idle("cmp", 100);
        check("cmp_port_sel", port_sel, 1);

        // LOADIFMAPS 1x1 reuses loaded weights, leaves bank unchanged
        issue(32'd88, 2'd2, 12'd1, 12'd8, 5'd1, mk("lif1", 0, 1, 0, 0, 0, 0, 0, 0));
        wait_idle("lif1", 50);
        check("lif1_port_sel", port_sel, 1);

        // COMPUTE 4x3 with FIFO toggling empty
        tog_en = 1'b1;
        issue(32'd87, 2'd2, 12'd4, 12'd8, 5'd3, mk("cmp_tog", 0, 12, 1, 1, 1, 0, 1, 1));
        wait_idle("cmp_tog", 200);
        tog_en = 1'b0;
        check("cmp_tog_port_sel", port_sel, 0);

        // Zero target: immediate completion with no beats
        issue(32'd88, 2'd0, 12'd0, 12'd1, 5'd3, mk("lif0", 0, 0, 0, 0, 0, 0, 0, 0));
        wait_idle("lif0", 50);

        // Largest target: 4095 x 5 must not truncate
        issue(32'd88, 2'd3, 12'd4095, 12'd4095, 5'd5, mk("lifmax", 0, 20475, 0, 0, 0, 0, 0, 0));
        wait_idle("lifmax", 21000);

        // Illegal instructions
        issue(32'd99, 2'd1, 12'd3, 12'd3, 5'd3, mk("bad_op", 1, 0, 0, 0, 0, 0, 0, 0));
        check("bad_op_busy", busy, 0);
        wait_idle("bad_op", 20);
        issue(32'd87, 2'd1, 12'd3, 12'd3, 5'd0, mk("bad_k0", 1, 0, 0, 0, 0, 0, 0, 0));
        check("bad_k0_busy", busy, 0);
        wait_idle("bad_k0", 20);
        issue(32'd88, 2'd1, 12'd3, 12'd3, 5'd6, mk("bad_k6", 1, 0, 0, 0, 0, 0, 0, 0));
        wait_idle("bad_k6", 20);
        check("bad_port_sel", port_sel, 0);

        // Timeout waiting on weight_from_bram_valid
        weight_from_bram_valid = 1'b0;
        issue(32'd87, 2'd2, 12'd2, 12'd2, 5'd2, mk("tmo", 1, 0, 1, 0, 0, 0, 0, 0));
        wait_idle("tmo", 1200);
        check("tmo_busy", busy, 0);
        check("tmo_port_sel", port_sel, 0);

        // Asynchronous reset mid-STREAM
        issue(32'd88, 2'd1, 12'd100, 12'd4, 5'd5, mk("rst_mid", 0, 500, 0, 0, 0, 0, 0, 0));
        repeat (10) @(negedge clk);
        check("rst_mid_busy_before", busy, 1);
        check("rst_mid_load_before", load_ifmaps, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_ctrl", {bram_write_en, bram_transfer_start, bram_control_add1,
              bram_control_add2, load_weight_preload, load_weight, load_ifmaps, done, err, busy}, 0);
        check("rst_mid_cfg", {operation, input_channel_size, output_channel_size, kernel_size}, 0);
        check("rst_mid_mac", mac_enable[31:0], 0);
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_ready", inst_ready, 1);

        issue(32'd88, 2'd1, 12'd2, 12'd2, 5'd2, mk("post_rst", 0, 4, 0, 0, 0, 0, 0, 0));
        wait_idle("post_rst", 50);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/conv_layer_sequencer.md
Name: conv_layer_sequencer

Overview:
- Instruction-driven controller that sequences the convolution datapath: weight BRAM fill, weight preload/load into the MAC array, and ifmap streaming.
- Accepts 32-bit instruction words over a valid/ready handshake and latches the layer configuration on accept.
- Drives every control input of data_path and consumes its status outputs (ifmaps_fifo_empty, weight_from_bram_valid, write_weight_finish).
- Sits between the host/instruction FIFO and data_path.

Parameters:
- MAC_NUM, 256, MAC columns; width of mac_enable.
- BEAT_CNT_WIDTH, 17, width of the ifmap beat counter; holds 12-bit channels x 5-bit kernel.
- WAIT_TIMEOUT, 1024, cycles allowed waiting on a BRAM status signal before the error pulse.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- inst_valid  in  1  instruction word valid.
- inst_ready  out  1  sequencer can accept an instruction.
- inst_data  in  32  opcode: 86=WRITE_WEIGHT, 87=COMPUTE, 88=LOADIFMAPS.
- cfg_operation  in  2  latched to operation on accept.
- cfg_in_ch  in  12  latched to input_channel_size on accept.
- cfg_out_ch  in  12  latched to output_channel_size on accept.
- cfg_kernel  in  5  latched to kernel_size on accept; legal range 1..5.
- cfg_mac_enable  in  MAC_NUM  latched to mac_enable on accept.
- operation, input_channel_size, output_channel_size, kernel_size, mac_enable  out  2/12/12/5/MAC_NUM  registered configuration.
- bram_write_en, bram_transfer_start, bram_control_add1, bram_control_add2, port_sel  out  1 each  BRAM controller controls.
- load_weight_preload, load_weight, load_ifmaps  out  1 each  MAC array controls.
- ifmaps_fifo_empty, weight_from_bram_valid, write_weight_finish  in  1 each  datapath status.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when an instruction completes.
- err  out  1  one-cycle pulse on bad opcode, illegal kernel size, or timeout.

Behaviour:
- Reset: all outputs 0, configuration registers 0, state IDLE, beat counter 0; port_sel resets to 0.
- Handshake: inst_ready = (state==IDLE). Accept when inst_valid && inst_ready; configuration latched the same edge.
- Bad opcode, or cfg_kernel of 0 or greater than 5: err pulses 1 cycle, stay IDLE, configuration still latched, no done.
- State machine: IDLE, WR_W, XFER, PRE, LDW, STREAM, FIN.
- WRITE_WEIGHT: IDLE->WR_W. bram_write_en held high until write_weight_finish is sampled 1, then WR_W->FIN.
- COMPUTE path IDLE->XFER: bram_transfer_start is a 1-cycle pulse on XFER entry; then XFER->PRE.
- PRE: wait for weight_from_bram_valid. The first cycle it is 1, assert load_weight_preload for exactly that cycle, pulse bram_control_add1, go to LDW.
- LDW: load_weight high for 1 cycle, then ->STREAM. Latency from accept to the first load_ifmaps opportunity is 4 cycles minimum.
- LOADIFMAPS: IDLE->STREAM directly, reusing the weights already loaded in the MAC array.
- STREAM: load_ifmaps = !ifmaps_fifo_empty, combinationally gated, never asserted while empty.
  - Beat counter increments on each cycle with load_ifmaps=1.
  - Target = input_channel_size*kernel_size, computed at BEAT_CNT_WIDTH bits with no truncation.
  - When the counter reaches target-1 with load_ifmaps=1: ->FIN, counter cleared.
  - Target 0 (in_ch=0): ->FIN immediately, no load_ifmaps.
- FIN: done pulses 1 cycle, ->IDLE. After COMPUTE, FIN also pulses bram_control_add2 and toggles port_sel (ping-pong bank).
- Timeout: a counter runs in WR_W and PRE. On reaching WAIT_TIMEOUT: err pulse, drop all controls, ->IDLE, no done.
- No wait in STREAM: an empty ifmap FIFO stalls the sequencer indefinitely.
- Exclusivity: only one of bram_write_en, load_weight_preload, load_weight, load_ifmaps is high in any cycle.
- Asynchronous reset mid-operation: immediate return to reset values; the partially loaded instruction is discarded.
- inst_valid while busy: ignored (ready=0), word held by the source.

Test Plan:
- WRITE_WEIGHT, write_weight_finish asserted 20 cycles later -> bram_write_en high exactly 20 cycles, done 1 cycle later, inst_ready back high.
- COMPUTE in_ch=4, kernel=3, FIFO never empty -> transfer_start pulse, preload 1 cycle on valid, load_weight 1 cycle, exactly 12 load_ifmaps cycles, done, port_sel toggles 0->1.
- Same COMPUTE with ifmaps_fifo_empty toggling every other cycle -> load_ifmaps never high while empty, still exactly 12 beats, done after about 24 cycles.
- LOADIFMAPS in_ch=1, kernel=1 -> no transfer_start/preload/load_weight, 1 beat, done, port_sel unchanged.
- Opcode 99, then kernel=0 with opcode 87 -> err pulse each time, no state change, no done.
- COMPUTE with weight_from_bram_valid held 0 -> err after 1024 cycles, busy drops; separately, rst_n asserted mid-STREAM -> all outputs 0 asynchronously.
